barcode_entry_sequencer: RTL and testbench

//  Sequences the 4-digit barcode shift register from a debounced keypad stream: forwards digits as one-cycle shift strobes,

---
 rtl/barcode_entry_sequencer.sv | 143 ++++++++++++++
 tb/tb_barcode_entry_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/barcode_entry_sequencer.sv
// barcode_entry_sequencer: keypad digits -> barcode shift strobes, entry count, timeout and product lookup handshake
module barcode_entry_sequencer #(
   parameter int DIGITS      = 4,
   parameter int TIMEOUT_CYC = 250000000,
   parameter int CNT_W       = 28
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       KEY_VALID,
   input  logic [3:0] KEY_CODE,
   output logic       BC_ENABLE,
   output logic [3:0] BC_DIGIT,
   output logic       BC_CLEAR_N,
   output logic [2:0] DIGIT_COUNT,
   output logic       LOOKUP_REQ,
   input  logic       LOOKUP_ACK,
   input  logic       LOOKUP_HIT,
   output logic       ITEM_VALID,
   output logic       ITEM_MISS,
   output logic       ENTRY_TMO,
   output logic       BUSY
);
   typedef enum logic [1:0] {IDLE, COLLECT, LOOKUP, FLUSH} state_t;
   localparam logic [2:0]       FULL     = 3'(DIGITS);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             en_q, en_d;
   logic [3:0]       dig_q, dig_d;
   logic             clr_n_q, clr_n_d;
   logic [2:0]       count_q, count_d;
   logic             req_q, req_d;
   logic             valid_q, valid_d;
   logic             miss_q, miss_d;
   logic             tmo_q, tmo_d;
   logic             busy_q, busy_d;
   logic             is_digit, is_clear, is_enter;
   assign is_digit = KEY_VALID && (KEY_CODE <= 4'd9);
   assign is_clear = KEY_VALID && (KEY_CODE == 4'hA);
   assign is_enter = KEY_VALID && (KEY_CODE == 4'hB);
   // next-state and next-output: every output is the registered image of what the state transition implies
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      en_d    = 1'b0;
      dig_d   = dig_q;
      clr_n_d = 1'b1;
      count_d = count_q;
      req_d   = 1'b0;
      valid_d = 1'b0;
      miss_d  = 1'b0;
      tmo_d   = 1'b0;
      busy_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (is_digit) begin
               en_d    = 1'b1;
               dig_d   = KEY_CODE;
               count_d = 3'd1;
               state_d = COLLECT;
            end
         end
         COLLECT: begin
            // any key activity restarts the idle timer and beats a simultaneous expiry
            if (KEY_VALID) begin
               if (is_digit && count_q < FULL) begin
                  en_d    = 1'b1;
                  dig_d   = KEY_CODE;
                  count_d = count_q + 3'd1;
               end else if (is_clear) begin
                  state_d = FLUSH;
                  clr_n_d = 1'b0;
                  count_d = '0;
                  busy_d  = 1'b1;
               end else if (is_enter && count_q == FULL) begin
                  state_d = LOOKUP;
                  req_d   = 1'b1;
                  busy_d  = 1'b1;
               end
            end else if (cnt_q == TMO_LAST) begin
               tmo_d   = 1'b1;
               state_d = FLUSH;
               clr_n_d = 1'b0;
               count_d = '0;
               busy_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         LOOKUP: begin
            busy_d = 1'b1;
            if (LOOKUP_ACK) begin
               valid_d = LOOKUP_HIT;
               miss_d  = !LOOKUP_HIT;
               state_d = FLUSH;
               clr_n_d = 1'b0;
               count_d = '0;
            end else begin
               req_d = 1'b1;
            end
         end
         FLUSH:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // state and output registers; reset holds the barcode register cleared and drops any pending request
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         en_q    <= 1'b0;
         dig_q   <= '0;
         clr_n_q <= 1'b0;
         count_q <= '0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         miss_q  <= 1'b0;
         tmo_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         dig_q   <= dig_d;
         clr_n_q <= clr_n_d;
         count_q <= count_d;
         req_q   <= req_d;
         valid_q <= valid_d;
         miss_q  <= miss_d;
         tmo_q   <= tmo_d;
         busy_q  <= busy_d;
      end
   end
   assign BC_ENABLE   = en_q;
   assign BC_DIGIT    = dig_q;
   assign BC_CLEAR_N  = clr_n_q;
   assign DIGIT_COUNT = count_q;
   assign LOOKUP_REQ  = req_q;
   assign ITEM_VALID  = valid_q;
   assign ITEM_MISS   = miss_q;
   assign ENTRY_TMO   = tmo_q;
   assign BUSY        = busy_q;
endmodule

// File: tb/tb_barcode_entry_sequencer.sv
// tb_barcode_entry_sequencer: directed scenarios plus random keypad/ack traffic against a behavioural model
module tb_barcode_entry_sequencer;
   localparam int DIGITS = 4;
   localparam int TMO    = 16;
   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       KEY_VALID = 1'b0;
   logic [3:0] KEY_CODE = '0;
   logic       LOOKUP_ACK = 1'b0;
   logic       LOOKUP_HIT = 1'b0;
   logic       BC_ENABLE, BC_CLEAR_N, LOOKUP_REQ, ITEM_VALID, ITEM_MISS, ENTRY_TMO, BUSY;
   logic [3:0] BC_DIGIT;
   logic [2:0] DIGIT_COUNT;
   int checks = 0;
   int failures = 0;
   int strobes = 0;
   int req_cycles = 0;
   barcode_entry_sequencer #(.DIGITS(DIGITS), .TIMEOUT_CYC(TMO), .CNT_W(8)) dut (
      .CLK(CLK), .RESET(RESET), .KEY_VALID(KEY_VALID), .KEY_CODE(KEY_CODE),
      .BC_ENABLE(BC_ENABLE), .BC_DIGIT(BC_DIGIT), .BC_CLEAR_N(BC_CLEAR_N),
      .DIGIT_COUNT(DIGIT_COUNT), .LOOKUP_REQ(LOOKUP_REQ), .LOOKUP_ACK(LOOKUP_ACK),
      .LOOKUP_HIT(LOOKUP_HIT), .ITEM_VALID(ITEM_VALID), .ITEM_MISS(ITEM_MISS),
      .ENTRY_TMO(ENTRY_TMO), .BUSY(BUSY)
   );
   always #5 CLK = ~CLK;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d at %0t", nm, act, exp, $time);
      end
   endtask
   // behavioural model: digits held as a queue, lookup/flush as flags, idle cycles as a plain count
   int   held[$];
   bit   in_lookup, flushing;
   int   idle;
   logic e_en, e_clrn, e_req, e_val, e_miss, e_tmo, e_busy;
   logic [3:0] e_dig;
   always @(posedge CLK) begin
      if (RESET) begin
         held.delete();
         in_lookup = 0; flushing = 0; idle = 0;
         e_en = 0; e_dig = 0; e_clrn = 0; e_req = 0; e_val = 0; e_miss = 0; e_tmo = 0; e_busy = 0;
      end else begin
         e_en = 0; e_val = 0; e_miss = 0; e_tmo = 0;
         if (flushing) flushing = 0;
         else if (in_lookup) begin
            if (LOOKUP_ACK) begin
               in_lookup = 0; flushing = 1; held.delete();
               if (LOOKUP_HIT) e_val = 1; else e_miss = 1;
            end
         end else if (held.size() == 0) begin
            if (KEY_VALID && KEY_CODE < 10) begin
               held.push_back(int'(KEY_CODE)); e_en = 1; e_dig = KEY_CODE; idle = 0;
            end
         end else if (KEY_VALID) begin
            idle = 0;
            if (KEY_CODE < 10) begin
               if (held.size() < DIGITS) begin
                  held.push_back(int'(KEY_CODE)); e_en = 1; e_dig = KEY_CODE;
               end
            end else if (KEY_CODE == 4'hA) begin
               flushing = 1; held.delete();
            end else if (KEY_CODE == 4'hB && held.size() == DIGITS) in_lookup = 1;
         end else if (idle == TMO - 1) begin
            e_tmo = 1; flushing = 1; held.delete();
         end else idle++;
         e_clrn = !flushing;
         e_req  = in_lookup;
         e_busy = flushing || in_lookup;
      end
      #1;
      chk("bc_enable", BC_ENABLE, e_en);
      if (e_en) chk("bc_digit", BC_DIGIT, e_dig);
      chk("bc_clear_n", BC_CLEAR_N, e_clrn);
      chk("digit_count", DIGIT_COUNT, held.size());
      chk("lookup_req", LOOKUP_REQ, e_req);
      chk("item_valid", ITEM_VALID, e_val);
      chk("item_miss", ITEM_MISS, e_miss);
      chk("entry_tmo", ENTRY_TMO, e_tmo);
      chk("busy", BUSY, e_busy);
      chk("pulse_exclusive", 32'(BC_ENABLE + ITEM_VALID + ITEM_MISS + ENTRY_TMO) <= 1 && !(BC_ENABLE && !BC_CLEAR_N), 1);
      if (BC_ENABLE) strobes++;
      if (LOOKUP_REQ) req_cycles++;
   end
   task automatic key(input logic [3:0] c);
      KEY_VALID = 1'b1; KEY_CODE = c;
      @(negedge CLK);
      KEY_VALID = 1'b0;
   endtask
   task automatic ack(input logic hit);
      LOOKUP_ACK = 1'b1; LOOKUP_HIT = hit;
      @(negedge CLK);
      LOOKUP_ACK = 1'b0;
   endtask
   task automatic keys4(input logic [15:0] d);
      for (int i = 3; i >= 0; i--) key(d[i*4 +: 4]);
   endtask
   initial begin
      int n;
      repeat (3) @(negedge CLK);
      chk("rst_clear_n", BC_CLEAR_N, 0);
      chk("rst_count", DIGIT_COUNT, 0);
      chk("rst_req", LOOKUP_REQ, 0);
      RESET = 1'b0;
      @(negedge CLK);
      chk("idle_clear_n", BC_CLEAR_N, 1);
      // T1
      strobes = 0; req_cycles = 0;
      keys4(16'h1234);
      chk("t1_count", DIGIT_COUNT, 4);
      key(4'hB);
      chk("t1_req", LOOKUP_REQ, 1);
      repeat (2) @(negedge CLK);
      ack(1'b1);
      chk("t1_item_valid", ITEM_VALID, 1);
      chk("t1_clear_n", BC_CLEAR_N, 0);
      chk("t1_count0", DIGIT_COUNT, 0);
      chk("t1_strobes", strobes, 4);
      chk("t1_req_cycles", req_cycles, 3);
      @(negedge CLK);
      chk("t1_idle_clear_n", BC_CLEAR_N, 1);
      // T2
      strobes = 0;
      keys4(16'h5678); key(4'h9); key(4'hB);
      chk("t2_strobes", strobes, 4);
      ack(1'b0);
      chk("t2_item_miss", ITEM_MISS, 1);
      @(negedge CLK);
      chk("t2_busy", BUSY, 0);
      // T3
      key(4'h1); key(4'h2); key(4'hB);
      chk("t3_no_req", LOOKUP_REQ, 0);
      chk("t3_count2", DIGIT_COUNT, 2);
      key(4'hA);
      chk("t3_flush_clear_n", BC_CLEAR_N, 0);
      chk("t3_count0", DIGIT_COUNT, 0);
      @(negedge CLK);
      // T4
      key(4'h3);
      n = 0;
      while (!ENTRY_TMO && n < 40) begin @(negedge CLK); n++; end
      chk("t4_tmo_delay", n, 16);
      chk("t4_tmo_clear_n", BC_CLEAR_N, 0);
      @(negedge CLK);
      key(4'h3);
      repeat (15) @(negedge CLK);
      key(4'h4);
      chk("t4_expiry_strobe", BC_ENABLE, 1);
      chk("t4_expiry_no_tmo", ENTRY_TMO, 0);
      chk("t4_expiry_count", DIGIT_COUNT, 2);
      key(4'hA);
      @(negedge CLK);
      // T5
      keys4(16'h4321); key(4'hB);
      strobes = 0;
      key(4'h5); key(4'hA); key(4'h7);
      chk("t5_no_strobes", strobes, 0);
      chk("t5_req_held", LOOKUP_REQ, 1);
      ack(1'b1);
      chk("t5_item_valid", ITEM_VALID, 1);
      @(negedge CLK);
      // T6
      keys4(16'h9999); key(4'hB);
      @(negedge CLK);
      RESET = 1'b1;
      #1;
      chk("t6_async_req", LOOKUP_REQ, 0);
      chk("t6_async_clear_n", BC_CLEAR_N, 0);
      @(negedge CLK);
      RESET = 1'b0;
      ack(1'b1);
      chk("t6_no_item", ITEM_VALID, 0);
      // random traffic
      for (int i = 0; i < 4000; i++) begin
         KEY_VALID  = ($urandom_range(0, 99) < 35);
         KEY_CODE   = ($urandom_range(0, 3) == 0) ? 4'hB : 4'($urandom_range(0, 15));
         LOOKUP_ACK = ($urandom_range(0, 9) < 2);
         LOOKUP_HIT = 1'($urandom_range(0, 1));
         RESET      = ($urandom_range(0, 599) == 0);
         if ($urandom_range(0, 99) == 0) begin
            KEY_VALID = 1'b0; LOOKUP_ACK = 1'b0;
            repeat (20) @(negedge CLK);
         end
         @(negedge CLK);
      end
      KEY_VALID = 1'b0; LOOKUP_ACK = 1'b0; RESET = 1'b0;
      repeat (3) @(negedge CLK);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
